// File: rtl/lsu_pkg.sv
// Shared funct3 width codes, FSM state encoding and request legality helpers for the LSU.
// Purely declarative: no logic, no latency, no flow control.
// Defines no flow control of its own; used by dmem_lsu and lsu_align.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  // Store codes SH/SW share the H/W encodings, so one check covers loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension, store lane merge.
// Latency: zero (pure combinational).
// No flow control; the caller decides when its outputs are consumed.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rd_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rd_word[15:8];
      2'd2:    w_byte = i_rd_word[23:16];
      2'd3:    w_byte = i_rd_word[31:24];
      default: w_byte = i_rd_word[7:0];
    endcase
    // Halfword lane is picked by addr[1] alone; addr[0] is either trapped or ignored upstream.
    w_half = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    o_ld_data = '0;
    case (i_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_ld_data = i_rd_word;
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = '0;
    endcase

    o_st_word = i_rd_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd1:    o_st_word[15:8]  = i_wdata[7:0];
          2'd2:    o_st_word[23:16] = i_wdata[7:0];
          2'd3:    o_st_word[31:24] = i_wdata[7:0];
          default: o_st_word[7:0]   = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) o_st_word[31:16] = i_wdata[15:0];
        else              o_st_word[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_st_word = i_wdata;
      default: o_st_word = i_rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit with read-modify-write sub-word stores; LSU_MISALIGN_CHECK_EN traps misaligned H/W.
// Latency from accept: error response 1 cycle, load 2, store 3.
// Backpressure: req_ready_o high only in IDLE, one request in flight; responses cannot be stalled.
module dmem_lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_st_en_o,
  output logic [10:0] mem_addr_o,
  output logic [31:0] mem_st_data_o,
  input  logic [31:0] mem_ld_data_i
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [10:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_misalign;
  logic        w_req_err;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_word;
  logic        w_unused_addr;

  assign w_unused_addr = |req_addr_i[31:11];

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = misaligned(req_funct3_i, req_addr_i[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err  = f3_illegal(req_we_i, req_funct3_i) | w_misalign;
  assign mem_addr_o = {r_addr[10:2], 2'b00};

  lsu_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_rd_word (r_rdata),
    .i_wdata   (r_wdata),
    .o_ld_data (w_ld_data),
    .o_st_word (w_st_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && req_valid_i) begin
        r_we     <= req_we_i;
        r_funct3 <= req_funct3_i;
        r_addr   <= req_addr_i[10:0];
        r_wdata  <= req_wdata_i;
        r_err    <= w_req_err;
      end
      if (r_state == ST_ACCESS)
        r_rdata <= mem_ld_data_i;
    end
  end

  // req_valid_i is used directly in IDLE instead of valid&ready to keep ready out of its own cone.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_err_o     = 1'b0;
    mem_st_en_o   = 1'b0;
    mem_st_data_o = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          w_state_nxt = w_req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: w_state_nxt = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        mem_st_en_o   = ~rst_i;
        mem_st_data_o = w_st_word;
        w_state_nxt   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = r_err;
        rsp_rdata_o = (r_we || r_err) ? 32'd0 : w_ld_data;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, reset-abort sequence, random requests vs a byte-array model.
// Honours LSU_MISALIGN_CHECK_EN when computing expectations.
module tb_dmem_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_st_en;
  logic [10:0] mem_addr;
  logic [31:0] mem_st_data;
  logic [31:0] mem_ld_data;

  dmem_lsu dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_funct3_i  (req_funct3),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .mem_st_en_o   (mem_st_en),
    .mem_addr_o    (mem_addr),
    .mem_st_data_o (mem_st_data),
    .mem_ld_data_i (mem_ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Data memory seen by the DUT: combinational read, word write on the strobe.
  logic [31:0] tb_mem [512];
  logic        mem_init;
  assign mem_ld_data = tb_mem[mem_addr[10:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < 512; w++) tb_mem[w] <= init_val(w);
    end else if (mem_st_en) begin
      tb_mem[mem_addr[10:2]] <= mem_st_data;
    end
  end

  // Reference model state: plain byte-addressed memory.
  logic [7:0] ref_mem [2048];

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int nst);
    int size;
    int a;
    logic legal;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    a     = int'(addr[10:0]);
    er    = !legal;
`ifdef LSU_MISALIGN_CHECK_EN
    if (legal && (a % size) != 0) er = 1'b1;
`endif
    rd  = '0;
    nst = 0;
    if (er) begin
      lat = 1;
    end else begin
      a = a - (a % size);
      if (we) begin
        lat = 3;
        nst = 1;
        for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        lat = 2;
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!f3[2] && size < 4 && v[8*size - 1])
          v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // Issue one request from IDLE and observe it until the response (bounded).
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string nm, output int lat,
                         output logic [31:0] rd, output logic er, output int nst);
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_idle_rsp"}, 32'(rsp_valid), 32'd0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = -1;
    nst = 0;
    rd  = '0;
    er  = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_st_en) nst++;
      if (!mem_st_en && mem_st_data != 32'd0) viol++;
      if (mem_addr[1:0] != 2'b00) viol++;
      if (mem_st_en && mem_addr != {addr[10:2], 2'b00}) viol++;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          nst;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input logic err,
                              input int lat, input int nst);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rd = rd; v.err = err; v.lat = lat; v.nst = nst;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    int          lat, nst, e_lat, e_nst, cnt_rsp, cnt_st, nbad;
    logic [31:0] rd, e_rd, word;
    logic        er, e_er, we;
    logic [2:0]  f3;
    logic [31:0] addr;
    string       nm;

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int b = 0; b < 2048; b++) begin
      word = init_val(b / 4);
      ref_mem[b] = word[8*(b % 4) +: 8];
    end

    vq.push_back(mk(1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 0, 3, 1));
    vq.push_back(mk(0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 0, 2, 0));
    vq.push_back(mk(1, 3'b010, 32'h020, 32'h11223344, 32'h0, 0, 3, 1));
    vq.push_back(mk(1, 3'b000, 32'h022, 32'h123456AA, 32'h0, 0, 3, 1));
    vq.push_back(mk(0, 3'b010, 32'h020, 32'h0, 32'h11AA3344, 0, 2, 0));
    vq.push_back(mk(1, 3'b010, 32'h030, 32'h80FF7F01, 32'h0, 0, 3, 1));
    vq.push_back(mk(0, 3'b000, 32'hFFFFF833, 32'h0, 32'hFFFFFF80, 0, 2, 0));
    vq.push_back(mk(0, 3'b100, 32'h033, 32'h0, 32'h00000080, 0, 2, 0));
    vq.push_back(mk(0, 3'b001, 32'h032, 32'h0, 32'hFFFF80FF, 0, 2, 0));
    vq.push_back(mk(0, 3'b101, 32'h030, 32'h0, 32'h00007F01, 0, 2, 0));
    vq.push_back(mk(1, 3'b010, 32'h040, 32'hCAFEF00D, 32'h0, 0, 3, 1));
    vq.push_back(mk(0, 3'b011, 32'h040, 32'h0, 32'h0, 1, 1, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    vq.push_back(mk(0, 3'b010, 32'h041, 32'h0, 32'h0, 1, 1, 0));
`else
    vq.push_back(mk(0, 3'b010, 32'h041, 32'h0, 32'hCAFEF00D, 0, 2, 0));
`endif
    vq.push_back(mk(1, 3'b011, 32'h044, 32'h0, 32'h0, 1, 1, 0));
    vq.push_back(mk(1, 3'b001, 32'h042, 32'h5555BEEF, 32'h0, 0, 3, 1));
    vq.push_back(mk(0, 3'b010, 32'h040, 32'h0, 32'hBEEFF00D, 0, 2, 0));
    vq.push_back(mk(1, 3'b100, 32'h040, 32'h0, 32'h0, 1, 1, 0));
    vq.push_back(mk(0, 3'b010, 32'h040, 32'h0, 32'hBEEFF00D, 0, 2, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_st_en", 32'(mem_st_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_st_data", mem_st_data, 32'd0);

    foreach (vq[i]) begin
      nm = $sformatf("vec%0d", i);
      run_req(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wd, nm, lat, rd, er, nst);
      chk({nm, "_rdata"}, rd, vq[i].rd);
      chk({nm, "_err"}, 32'(er), 32'(vq[i].err));
      chk({nm, "_lat"}, 32'(lat), 32'(vq[i].lat));
      chk({nm, "_st_pulses"}, 32'(nst), 32'(vq[i].nst));
      model(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wd, e_rd, e_er, e_lat, e_nst);
    end

    // Reset lands while the SW to 0x050 sits in WRITE: the write and its response must vanish.
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h050; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_write", 32'(mem_st_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_gated", 32'(mem_st_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    chk("abort_addr_cleared", 32'(mem_addr), 32'd0);
    cnt_rsp = 0; cnt_st = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) cnt_rsp++;
      if (mem_st_en) cnt_st++;
      @(negedge clk);
    end
    chk("abort_no_rsp", 32'(cnt_rsp), 32'd0);
    chk("abort_no_store", 32'(cnt_st), 32'd0);
    chk("abort_word", tb_mem[32'h050 >> 2],
        {ref_mem[32'h053], ref_mem[32'h052], ref_mem[32'h051], ref_mem[32'h050]});

    for (int n = 0; n < 150; n++) begin
      int k;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        k  = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      addr = ($urandom & 32'hFFFFF800) | 32'($urandom_range(0, 63));
      word = $urandom;
      model(we, f3, addr, word, e_rd, e_er, e_lat, e_nst);
      nm = $sformatf("rnd%0d", n);
      run_req(we, f3, addr, word, nm, lat, rd, er, nst);
      chk({nm, "_rdata"}, rd, e_rd);
      chk({nm, "_err"}, 32'(er), 32'(e_er));
      chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
      chk({nm, "_st_pulses"}, 32'(nst), 32'(e_nst));
    end

    @(negedge clk);
    nbad = 0;
    for (int w = 0; w < 512; w++) begin
      if (tb_mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
        nbad++;
    end
    chk("mem_final_words", 32'(nbad), 32'd0);
    chk("bus_monitor", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
